// File: rtl/board_button_events.sv
// Classifies debounced push-button gestures into one-cycle event pulses:
// short press, long press, auto-repeat while held, and double click.
module board_button_events #(
  parameter int CNT_W      = 26,
  parameter int LONG_CYC   = 50_000_000,
  parameter int DBL_CYC    = 15_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic double_click,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    WAIT_GAP = 3'd3,
    SECOND   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lvl_d;
  logic             rise;
  logic             short_nxt, long_nxt, repeat_nxt, double_nxt;

  assign rise = db_level & ~lvl_d;
  assign busy = (state != IDLE);

  // lvl_d resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lvl_d        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      double_click <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lvl_d        <= db_level;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      repeat_tick  <= repeat_nxt;
      double_click <= double_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        // Release takes priority over the long-press timeout.
        if (!db_level) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!db_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        // A second press takes priority over closing the double-click window.
        if (db_level) begin
          state_nxt = SECOND;
          cnt_nxt   = '0;
        end else if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SECOND: begin
        if (!db_level) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
